// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, FSM states and the byte-merge helper for the CLINT
package clint_pkg;
   localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;
   typedef enum logic {CLINT_IDLE, CLINT_RESP} clint_state_t;
   function automatic logic [63:0] clint_merge(input logic [63:0] old, input logic [63:0] wdata, input logic [7:0] wmask);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{wmask[i]}};
      return (old & ~m) | (wdata & m);
   endfunction
endpackage

// File: rtl/clint_if.sv
// clint_if: single-request valid/ready bus between the data-memory master and the CLINT
interface clint_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   modport master(output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
   modport slave(input req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/clint_prescaler.sv
// clint_prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as a one-cycle tick
module clint_prescaler #(parameter int TICK_DIV = 1) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [W-1:0] cnt;
   assign tick = cnt == W'(TICK_DIV - 1);
   // free-running divider, restarts on wrap
   always_ff @(posedge clk)
      if (!rst_n) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/clint.sv
// clint: machine timer, timer compare and software interrupt; msip implemented only with CLINT_MSIP_EN
module clint import clint_pkg::*; #(
   parameter int          TICK_DIV  = 1,
   parameter logic [15:0] BASE_MASK = 16'hFFFF
) (
   input  logic    clk,
   input  logic    rst_n,
   clint_if.slave  bus,
   output logic    clint_mtip,
   output logic    clint_msip
);
   clint_state_t state;
   logic [63:0]  mtime, mtimecmp, rdata;
   logic [12:0]  off;
   logic         tick, acc, hit_msip, hit_cmp, hit_time, msip, unused_ok;
   clint_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (.clk(clk), .rst_n(rst_n), .tick(tick));
   assign unused_ok = ^bus.req_addr[2:0];
   assign off       = bus.req_addr[15:3] & BASE_MASK[15:3];
   assign hit_msip  = off == CLINT_MSIP_OFF[15:3];
   assign hit_cmp   = off == CLINT_MTIMECMP_OFF[15:3];
   assign hit_time  = off == CLINT_MTIME_OFF[15:3];
   assign acc       = state == CLINT_IDLE && bus.req_valid;
   assign rdata     = hit_msip ? {63'd0, msip} : hit_cmp ? mtimecmp : hit_time ? mtime : '0;
   assign clint_msip = msip;
   // timer registers; a write to mtime overrides a same-edge tick
   always_ff @(posedge clk)
      if (!rst_n) begin
         mtime      <= '0;
         mtimecmp   <= '1;
         clint_mtip <= 1'b0;
      end else begin
         mtime      <= acc && bus.req_wen && hit_time ? clint_merge(mtime, bus.req_wdata, bus.req_wmask) : mtime + 64'(tick);
         mtimecmp   <= acc && bus.req_wen && hit_cmp ? clint_merge(mtimecmp, bus.req_wdata, bus.req_wmask) : mtimecmp;
         clint_mtip <= mtime >= mtimecmp;
      end
`ifdef CLINT_MSIP_EN
   // software interrupt bit, visible on clint_msip at the writing edge
   always_ff @(posedge clk)
      if (!rst_n) msip <= 1'b0;
      else if (acc && bus.req_wen && hit_msip && bus.req_wmask[0]) msip <= bus.req_wdata[0];
`else
   assign msip = 1'b0;
`endif
   // request/response handshake; read data is captured at acceptance
   always_ff @(posedge clk)
      if (!rst_n) begin
         state         <= CLINT_IDLE;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else if (acc) begin
         state         <= CLINT_RESP;
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b1;
         bus.rsp_rdata <= bus.req_wen ? '0 : rdata;
         bus.rsp_err   <= !(hit_msip || hit_cmp || hit_time);
      end else if (state == CLINT_RESP && bus.rsp_ready) begin
         state         <= CLINT_IDLE;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
      end
endmodule

// File: doc/clint.md
# clint

Core-local interruptor: owns the machine timer (`mtime`), timer compare (`mtimecmp`) and software-interrupt (`msip`) registers, and drives the `clint_mtip` / `clint_msip` lines into the core's CSR/interrupt unit. It sits on the data-memory side as a memory-mapped slave behind a single-request valid/ready port. It is the producer end of the timer-interrupt path that the core's trap logic consumes.

## Interface
- `TICK_DIV`, default 1: `clk` cycles per `mtime` increment; must be ≥1.
- `BASE_MASK`, default 16'hFFFF: address bits decoded, as an offset within the CLINT window.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: bus request present.
- `req_ready` out 1: slave can accept a request.
- `req_wen` in 1: 1 = write, 0 = read.
- `req_addr` in 16: byte offset within the CLINT window; bits [2:0] ignored, 64-bit access only.
- `req_wdata` in 64: write data.
- `req_wmask` in 8: byte enables for writes.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: master accepts response.
- `rsp_rdata` out 64: read data; 0 for writes.
- `rsp_err` out 1: access hit an unmapped offset.
- `clint_mtip` out 1: timer interrupt pending, level.
- `clint_msip` out 1: software interrupt pending, level.

## Operation
- Register map (offset): 0x0000 `msip` (bit 0 only, other bits read 0), 0x4000 `mtimecmp`, 0xBFF8 `mtime`. Any other offset: read data 0, `rsp_err`=1, write ignored.
- Writes are byte-merged: new = (old & ~mask64) | (wdata & mask64), where mask64 expands `req_wmask`.
- Prescaler counts 0..TICK_DIV-1; on wrap, `mtime` increments by 1, wrapping 2^64-1 → 0.
- Write to `mtime` in the same cycle as a tick: the merged write value is stored and the tick is dropped.
- `clint_mtip` is registered: `mtime >= mtimecmp` (unsigned), evaluated on current register values.
- FSM: IDLE (`req_ready`=1) → accept on `req_valid` → RESP (`rsp_valid`=1, `req_ready`=0) → back to IDLE on `rsp_ready`. Read data is captured at acceptance and held stable in RESP.
- Reset values: `mtime`=0, `mtimecmp`=all ones, `msip`=0, prescaler=0, FSM=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `clint_mtip`=0, `clint_msip`=0.
- Reset asserted in RESP: the response is dropped and no write is replayed.

## Timing
- Request accepted at edge N: the register write takes effect at N; `rsp_valid` is high from N until the edge on which `rsp_ready` is sampled high.
- Back-to-back throughput: one access per two cycles when `rsp_ready` is held high.
- A `mtime`/`mtimecmp` change at edge N is reflected on `clint_mtip` at edge N+1. An `msip` write at edge N is reflected on `clint_msip` at N (same edge; it is a direct register).
- A read of `mtime` returns its value before any same-edge increment.

## Configuration
- `CLINT_MSIP_EN` defined: the `msip` register is implemented as above.
- `CLINT_MSIP_EN` undefined: offset 0x0000 reads 0 with `rsp_err`=0, writes are ignored, and `clint_msip` is tied 0.

## Structure
- `clint_pkg` holds the offset constants (`CLINT_MSIP_OFF`, `CLINT_MTIMECMP_OFF`, `CLINT_MTIME_OFF`) and the FSM state enum (`CLINT_IDLE`, `CLINT_RESP`).
- One sub-module, `clint_prescaler`: counter with `TICK_DIV` parameter and a one-cycle `tick` output.

## Test plan
- Reset, then TICK_DIV=1 and no writes: `mtime` reads 5 after 5 cycles; `clint_mtip`=0 throughout.
- Write `mtimecmp`=0x20 with `mtime`≈0x10: `clint_mtip` rises exactly one edge after `mtime` reaches 0x20. Rewrite `mtimecmp`=0xFFFF: `clint_mtip` falls one edge after the write.
- Write `mtime`=0xFFFF_FFFF_FFFF_FFFF: it reads 0 after one tick. The same write coincident with a tick stores the written value and the tick is lost.
- Byte-masked write of 0xAABB to `mtimecmp` with `req_wmask`=8'h03 from all-ones: reads 0xFFFF_FFFF_FFFF_AABB.
- Read of offset 0x1234: `rsp_err`=1, `rsp_rdata`=0. Holding `rsp_ready`=0 for 3 cycles keeps `rsp_valid` and data stable and `req_ready`=0.
- `msip` write 1: `clint_msip`=1 when `CLINT_MSIP_EN` is defined, and stays 0 with the read returning 0 when it is undefined. `rst_n` low mid-RESP yields `rsp_valid`=0 on the next edge.
